gate_truth_table_checker: RTL

//  On-chip exhaustive truth-table checker for small combinational gates.

---
 rtl/gate_truth_table_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/gate_truth_table_checker.sv
// Exhaustive on-chip truth-table checker: walks every N_IN-bit vector, waits, samples dut_y, scores it.
// Optional GTT_STOP_ON_FAIL_EN: the first mismatch ends the run early.
module gate_truth_table_checker #(
  parameter int                 N_IN          = 2,
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE   = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_a,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_count,
  output logic [N_IN-1:0] first_fail_vec
);

`ifdef GTT_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [7:0]      SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam state_t          FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t          state, state_next;
  logic [N_IN-1:0] vec, vec_next;
  logic [7:0]      cnt, cnt_next;
  logic [7:0]      err_next;
  logic [N_IN-1:0] ffv_next;
  logic            pass_next;
  logic            mismatch;
  logic            last_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else begin
      state          <= state_next;
      vec            <= vec_next;
      cnt            <= cnt_next;
      err_count      <= err_next;
      first_fail_vec <= ffv_next;
      pass           <= pass_next;
    end
  end

  always_comb begin
    state_next  = state;
    vec_next    = vec;
    cnt_next    = cnt;
    err_next    = err_count;
    ffv_next    = first_fail_vec;
    pass_next   = pass;
    mismatch    = (dut_y != TRUTH_TABLE[vec]);
    last_sample = (vec == LAST_VEC) || (STOP_ON_FAIL && mismatch);
    dut_a       = '0;
    busy        = (state != IDLE);
    done        = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          state_next = FIRST_STATE;
          vec_next   = '0;
          cnt_next   = '0;
          err_next   = '0;
          ffv_next   = '0;
          pass_next  = 1'b0;
        end
      end
      SETTLE: begin
        dut_a = vec;
        if (cnt == SETTLE_LAST) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      SAMPLE: begin
        dut_a = vec;
        // first_fail_vec latches only on the transition of err_count away from zero
        if (mismatch) begin
          if (err_count != 8'd255) err_next = err_count + 8'd1;
          if (err_count == 8'd0)   ffv_next = vec;
        end
        if (last_sample) begin
          state_next = DONE;
          pass_next  = (err_count == 8'd0) && !mismatch;
        end else begin
          state_next = FIRST_STATE;
          vec_next   = vec + 1'b1;
          cnt_next   = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
